// File: rtl/power_good_gen.sv
// power_good_gen: rail supervisor. Drives the regulator enable, synchronizes
// the asynchronous rail comparator, qualifies it with assert/deassert counters
// and retries failed ramps a bounded number of times before latching a fault.
module power_good_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int ASSERT_CYCLES   = 20,
  parameter int DEASSERT_CYCLES = 3,
  parameter int RAMP_TIMEOUT    = 50,
  parameter int COOLDOWN_CYCLES = 10,
  parameter int MAX_RETRIES     = 3
) (
  input  logic                               clk,
  input  logic                               resetb,
  input  logic                               rail_en_req,
  input  logic                               rail_ok_raw,
  output logic                               rail_on,
  output logic                               power_good,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
);

  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int GW = $clog2(ASSERT_CYCLES + 1);
  localparam int BW = $clog2(DEASSERT_CYCLES + 1);
  localparam int TW = $clog2(RAMP_TIMEOUT + 1);
  localparam int CW = $clog2(COOLDOWN_CYCLES + 1);

  // "Last" values: the counter holds LIMIT-1 on the cycle whose edge reaches the limit.
  localparam logic [GW-1:0] GOOD_LAST = GW'(ASSERT_CYCLES - 32'sd1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(DEASSERT_CYCLES - 32'sd1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(RAMP_TIMEOUT - 32'sd1);
  localparam logic [CW-1:0] CD_LAST   = CW'(COOLDOWN_CYCLES - 32'sd1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_RAMP  = 3'd1,
    ST_GOOD  = 3'd2,
    ST_COOL  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ok_s;
  logic [GW-1:0]          good_cnt_q, good_cnt_d;
  logic [BW-1:0]          bad_cnt_q, bad_cnt_d;
  logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
  logic [CW-1:0]          cd_cnt_q, cd_cnt_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic                   retry_inc;
  logic                   rail_on_q, rail_on_d;
  logic                   pg_q, pg_d;
  logic                   fault_q, fault_d;

  assign ok_s = sync_q[SYNC_STAGES-1];

  // Synchronizer chain for the asynchronous comparator output.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rail_ok_raw};
    end
  end

  // Next-state logic; request removal overrides every other transition.
  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (rail_en_req) state_d = ST_RAMP;
        else             state_d = ST_OFF;
      end
      ST_RAMP: begin
        if (!rail_en_req) begin
          state_d = ST_OFF;
        end else if (ok_s && (good_cnt_q == GOOD_LAST)) begin
          state_d = ST_GOOD;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = ST_COOL;
          retry_inc = 1'b1;
        end else begin
          state_d = ST_RAMP;
        end
      end
      ST_GOOD: begin
        if (!rail_en_req) begin
          state_d = ST_OFF;
        end else if (!ok_s && (bad_cnt_q == BAD_LAST)) begin
          state_d   = ST_COOL;
          retry_inc = 1'b1;
        end else begin
          state_d = ST_GOOD;
        end
      end
      ST_COOL: begin
        if (!rail_en_req) begin
          state_d = ST_OFF;
        end else if (cd_cnt_q == CD_LAST) begin
          if (retry_q == RETRY_MAX) state_d = ST_FAULT;
          else                      state_d = ST_RAMP;
        end else begin
          state_d = ST_COOL;
        end
      end
      ST_FAULT: begin
        if (!rail_en_req) state_d = ST_OFF;
        else              state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  // Qualification counters: cleared on every state entry, advanced only while staying.
  always_comb begin
    good_cnt_d = '0;
    bad_cnt_d  = '0;
    tmo_cnt_d  = '0;
    cd_cnt_d   = '0;
    if (state_d == state_q) begin
      case (state_q)
        ST_RAMP: begin
          tmo_cnt_d = tmo_cnt_q + TW'(1'b1);
          if (ok_s) good_cnt_d = good_cnt_q + GW'(1'b1);
          else      good_cnt_d = '0;
        end
        ST_GOOD: begin
          if (!ok_s) bad_cnt_d = bad_cnt_q + BW'(1'b1);
          else       bad_cnt_d = '0;
        end
        ST_COOL: begin
          cd_cnt_d = cd_cnt_q + CW'(1'b1);
        end
        default: begin
          good_cnt_d = '0;
          bad_cnt_d  = '0;
          tmo_cnt_d  = '0;
          cd_cnt_d   = '0;
        end
      endcase
    end else begin
      good_cnt_d = '0;
      bad_cnt_d  = '0;
      tmo_cnt_d  = '0;
      cd_cnt_d   = '0;
    end
  end

  // Retry counter: cleared in OFF, saturating increment on each failed attempt.
  always_comb begin
    if (state_d == ST_OFF) begin
      retry_d = '0;
    end else if (retry_inc && (retry_q != RETRY_MAX)) begin
      retry_d = retry_q + RW'(1'b1);
    end else begin
      retry_d = retry_q;
    end
  end

  // Output decode from the next state so the flops change on the transition edge.
  always_comb begin
    rail_on_d = (state_d == ST_RAMP) || (state_d == ST_GOOD);
    pg_d      = (state_d == ST_GOOD);
    fault_d   = (state_d == ST_FAULT);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q    <= ST_OFF;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      cd_cnt_q   <= '0;
      retry_q    <= '0;
      rail_on_q  <= 1'b0;
      pg_q       <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      cd_cnt_q   <= cd_cnt_d;
      retry_q    <= retry_d;
      rail_on_q  <= rail_on_d;
      pg_q       <= pg_d;
      fault_q    <= fault_d;
    end
  end

  assign rail_on    = rail_on_q;
  assign power_good = pg_q;
  assign fault      = fault_q;
  assign retry_cnt  = retry_q;

endmodule

// File: doc/power_good_gen.md
# power_good_gen

Rail supervisor that produces the `power_good` signal consumed by the downstream `power_on` sequencer. It drives the regulator enable, samples the asynchronous rail comparator, and filters it through a synchronizer and qualification counters. It asserts `power_good` only after a stable ramp, drops it only on a sustained fault, and retries failed ramps a bounded number of times before latching a fault. It sits between the board regulator/comparator and `power_on`.

## Interface
- `SYNC_STAGES`, 2, synchronizer depth for `rail_ok_raw` (≥2)
- `ASSERT_CYCLES`, 20, consecutive synced-good cycles required to assert `power_good`
- `DEASSERT_CYCLES`, 3, consecutive synced-bad cycles required to drop `power_good`
- `RAMP_TIMEOUT`, 50, max cycles in RAMP before the attempt is declared failed
- `COOLDOWN_CYCLES`, 10, cycles `rail_on` is held low between attempts
- `MAX_RETRIES`, 3, failed attempts tolerated before FAULT

Ports:
- `clk`  in  1  system clock
- `resetb`  in  1  reset, asynchronous, active-low
- `rail_en_req`  in  1  synchronous request to power the rail
- `rail_ok_raw`  in  1  asynchronous comparator output; 1 = rail in range
- `rail_on`  out  1  regulator enable, registered
- `power_good`  out  1  qualified rail status to `power_on`, registered
- `fault`  out  1  latched fault, registered
- `retry_cnt`  out  $clog2(MAX_RETRIES+1)  failed attempts since last OFF

## Operation
- Reset: state OFF; `rail_on`=0, `power_good`=0, `fault`=0, `retry_cnt`=0, all counters and sync flops 0.
- `ok_s` = `rail_ok_raw` after `SYNC_STAGES` flops. All decisions use `ok_s` only.
- OFF: all outputs 0 except `fault`=0. `rail_en_req`=1 → RAMP; `rail_on`=1 from the same edge.
- RAMP: `rail_on`=1. `good_cnt` increments on each cycle with `ok_s`=1 and clears on `ok_s`=0. `tmo_cnt` increments every cycle.
  - When `good_cnt` reaches `ASSERT_CYCLES` → GOOD, with `power_good`=1 on that edge.
  - Otherwise, when `tmo_cnt` reaches `RAMP_TIMEOUT` → COOLDOWN and `retry_cnt`+1.
  - If both occur on the same edge, GOOD wins.
- GOOD: `power_good`=1, `rail_on`=1. `bad_cnt` increments on `ok_s`=0 and clears on `ok_s`=1.
  - When `bad_cnt` reaches `DEASSERT_CYCLES` → COOLDOWN, with `power_good`=0 and `rail_on`=0 on that edge, and `retry_cnt`+1.
  - Glitches shorter than `DEASSERT_CYCLES` are invisible on `power_good`.
- COOLDOWN: `rail_on`=0, `power_good`=0 for exactly `COOLDOWN_CYCLES` cycles. Then:
  - if `retry_cnt`==`MAX_RETRIES` → FAULT;
  - else → RAMP.
- FAULT: `rail_on`=0, `power_good`=0, `fault`=1. The block stays in FAULT while `rail_en_req`=1. `rail_en_req`=0 → OFF, clearing `fault` and `retry_cnt`.
- `rail_en_req`=0 in RAMP, GOOD or COOLDOWN → OFF on the next edge. `rail_on`, `power_good` and `retry_cnt` are 0 after that edge. Request removal has priority over every other transition.
- `retry_cnt` saturates at `MAX_RETRIES` and clears only on entry to OFF.
- Counters are sized to hold their limit and clear on every state entry.
- Async reset mid-operation forces the reset values immediately, independent of `clk`.

## Timing
- Edge E0: first edge at which `rail_ok_raw`=1 is sampled, while in RAMP and held high afterwards.
  - `ok_s` is high after edge E0+`SYNC_STAGES`−1.
  - `power_good` is high after edge E0+`SYNC_STAGES`−1+`ASSERT_CYCLES`. With defaults this is E0+21, i.e. 210 ns at 100 MHz.
- Drop latency: first low sample at edge E0 while in GOOD. `power_good` is low after edge E0+`SYNC_STAGES`−1+`DEASSERT_CYCLES`. With defaults this is E0+4.
- Request removal: `rail_en_req` sampled 0 at edge E → `rail_on`=0 and `power_good`=0 after edge E (1-cycle latency).
- `power_good` never asserts while `rail_on`=0. `power_good` and `rail_on` are glitch-free (flop outputs).
- Minimum `power_good` low time between GOOD periods is `COOLDOWN_CYCLES`+`SYNC_STAGES`−1+`ASSERT_CYCLES` cycles. This is ≥31 cycles with defaults, which guarantees `power_on` fully re-qualifies.

## Test plan
- Normal bring-up: reset, `rail_en_req`=1, `rail_ok_raw`=1 at 50 ns → `rail_on`=1 next edge; `power_good` rises 21 cycles after `rail_ok_raw` is first sampled; `retry_cnt`=0, `fault`=0.
- Glitch filter: in GOOD, pulse `rail_ok_raw` low for 20 ns (2 cycles) → `power_good` stays 1. Then hold it low 40 ns → `power_good` falls after 4 cycles, `rail_on`=0, `retry_cnt`=1, COOLDOWN lasts 10 cycles, `rail_on` returns to 1.
- Ramp timeout: `rail_en_req`=1 with `rail_ok_raw`=0 → `rail_on` high 50 cycles, then low 10 cycles, repeated. After the 3rd timeout and its cooldown, `fault`=1 and `rail_on`=0 permanently. Drop `rail_en_req` → `fault`=0 and `retry_cnt`=0 next edge.
- Chatter in RAMP: `rail_ok_raw` toggles every 100 ns → `good_cnt` never reaches 20; `power_good` never asserts; timeout path is taken.
- Request removal: deassert `rail_en_req` in GOOD, and separately mid-COOLDOWN → `rail_on`=`power_good`=0 one edge later; reassert → fresh RAMP with `retry_cnt`=0.
- Async reset: pull `resetb` low 10 ns while in GOOD → all outputs 0 immediately. After release with `rail_ok_raw`=1, `power_good` returns 21 cycles after the first sample in RAMP.
